fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the program counter (PC) and sequences instruction fetch from instruction memory over a req/ack handshake.
- Presents fetched instructions to the IF/ID register and honours stalls from the hazard unit.
- Applies redirects (taken branch, j, jr) produced by the next-PC logic: it squashes wrong-path fetches and raises a flush.
- Sits between the next-PC logic, the instruction memory port and IF/ID. All addresses are 30-bit word addresses.

Parameters:
- RESET_ADDR, 30'h0010_0000, word address of the first fetch (byte address 0x0040_0000).
- AW, 30, word-address width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_stall  in  1  IF/ID cannot accept; the current o_if_* must be held.
- i_PCSrc  in  1  redirect pulse from the next-PC logic.
- i_target  in  30  redirect word address; valid when i_PCSrc=1.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  30  fetch word address.
- i_imem_ack  in  1  memory returns data this cycle; may arrive in the same cycle as req.
- i_imem_rdata  in  32  instruction word.
- o_if_valid  out  1  o_if_instr and o_if_inc_PC are valid.
- o_if_instr  out  32  fetched instruction.
- o_if_inc_PC  out  30  fetch address + 1.
- o_flush  out  1  combinational; equals i_PCSrc; clears downstream IF/ID.

Behaviour:
- Reset (async): pc=RESET_ADDR, state=BOOT, o_if_valid=0, o_if_instr=0, o_if_inc_PC=0, redir_pend=0, redir_addr=0. While reset is asserted, o_imem_req=0.
- o_imem_addr = pc at all times. pc must not change while a request is outstanding (req=1 without ack).
- slot_free = ~o_if_valid | ~i_stall. The slot is consumed when o_if_valid & ~i_stall; o_if_valid then clears next cycle unless a new capture occurs.
- BOOT: req=0. Next state HOLD.
- HOLD: req = slot_free.
  - req & ack in the same cycle: capture, then stay in HOLD.
  - req & ~ack: go to FETCH.
  - ~req: stay in HOLD with outputs held.
- FETCH: req=1 and the slot is empty.
  - On ack: capture, go to HOLD.
  - Otherwise stay in FETCH.
- Capture: o_if_instr<=rdata, o_if_inc_PC<=pc+1, o_if_valid<=1, pc<=pc+1.
- Zero-wait memory with no stalls gives one instruction per cycle.
- pc+1 wraps modulo 2^30 with no flag.
- Redirect (i_PCSrc=1) in any state except BOOT:
  - o_if_valid<=0.
  - If a request is outstanding without ack: redir_pend<=1, redir_addr<=i_target, go to SQUASH.
  - If req & ack in the same cycle: discard rdata, pc<=i_target, go to HOLD.
  - If no request this cycle: pc<=i_target, stay in HOLD.
  - Redirect has priority over capture.
- SQUASH: req=1 with the old pc until ack.
  - On ack: discard data, pc<=redir_addr, redir_pend<=0, go to HOLD.
  - A further i_PCSrc in SQUASH overwrites redir_addr (the latest redirect wins).
  - A redirect that coincides with the squash ack uses i_target directly.
- Redirect in BOOT: pc<=i_target; the state still advances to HOLD.
- i_stall has no effect on the imem handshake once req is asserted.
- Reset mid-transaction: the state machine returns to BOOT immediately. The memory side must tolerate a dropped req.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs o_perf_fetch[31:0] and o_perf_squash[31:0].
  - o_perf_fetch counts captures; o_perf_squash counts discarded acks.
  - Both reset to 0, saturate at 32'hFFFF_FFFF and update on the cycle of the event.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding: BOOT=2'd0, HOLD=2'd1, FETCH=2'd2, SQUASH=2'd3;
  - AW=30;
  - the default RESET_ADDR, also used by the next-PC logic and the testbench.
- One natural sub-module: fetch_perf_cnt (saturating 32-bit counter with an increment enable), instantiated twice under FETCH_PERF_EN.
- Everything else lives in fetch_sequencer.

Test Plan:
- Reset, zero-wait memory with ack=req, no stalls -> first req at addr 0x0010_0000 in cycle 1 after BOOT; o_if_inc_PC = 0x0010_0001, 0x0010_0002, ... one per cycle.
- ack delayed 3 cycles on each request -> o_imem_addr stable during the wait; one capture per 4 cycles; o_if_valid pulses.
- i_stall=1 for 5 cycles while o_if_valid=1 -> o_if_instr and o_if_inc_PC held; req=0; on stall release, req rises in the same cycle.
- i_PCSrc with i_target=0x0000_0100 while a request to 0x0010_0003 is outstanding with ack 2 cycles later -> o_flush=1 that cycle; the ack data is discarded; the next req goes to 0x0000_0100. With FETCH_PERF_EN, squash count = 1.
- Two redirects (0x40, then 0x80) during one SQUASH -> next fetch address is 0x80.
- RESET_ADDR=30'h3FFF_FFFF -> the second fetch address wraps to 0x0000_0000; async reset asserted mid-FETCH -> req=0 immediately and pc=RESET_ADDR.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, address width
// and the default reset fetch address (also used by the next-PC logic).
package fetch_sequencer_pkg;

  localparam int unsigned AW = 30;

  // Word address 0x0010_0000 == byte address 0x0040_0000
  localparam logic [AW-1:0] RESET_ADDR_DEFAULT = 30'h0010_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    HOLD   = 2'd1,
    FETCH  = 2'd2,
    SQUASH = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter with an increment enable.
module fetch_perf_cnt (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] count_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (i_inc && (count_q != '1)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction-fetch sequencer (req/ack imem port, IF/ID slot, redirects).
// Optional FETCH_PERF_EN adds saturating fetch/squash counters.
module fetch_sequencer #(
  parameter int unsigned     AW         = fetch_sequencer_pkg::AW,
  parameter logic [AW-1:0]   RESET_ADDR = fetch_sequencer_pkg::RESET_ADDR_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic          i_PCSrc,
  input  logic [AW-1:0] i_target,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_ack,
  input  logic [31:0]   i_imem_rdata,
  output logic          o_if_valid,
  output logic [31:0]   o_if_instr,
  output logic [AW-1:0] o_if_inc_PC,
  output logic          o_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   o_perf_fetch,
  output logic [31:0]   o_perf_squash
`endif
);

  import fetch_sequencer_pkg::*;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] redir_q, redir_d;
  logic [AW-1:0] inc_q, inc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          req, slot_free, capture;

  // A pending redirect is implied by SQUASH; redir_q holds its target.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    inc_d     = inc_q;
    instr_d   = instr_q;
    valid_d   = valid_q & i_stall;
    req       = 1'b0;
    capture   = 1'b0;
    slot_free = ~valid_q | ~i_stall;

    case (state_q)
      BOOT: begin
        state_d = HOLD;
        if (i_PCSrc) pc_d = i_target;
      end
      HOLD:          req = slot_free;
      FETCH, SQUASH: req = 1'b1;
      default:       req = 1'b0;
    endcase

    if (state_q != BOOT) begin
      if (i_PCSrc) begin
        valid_d = 1'b0;
        if (req & i_imem_ack) begin
          pc_d    = i_target;
          state_d = HOLD;
        end else if (req) begin
          redir_d = i_target;
          state_d = SQUASH;
        end else begin
          pc_d = i_target;
        end
      end else if (req & i_imem_ack) begin
        if (state_q == SQUASH) pc_d = redir_q;
        else                   capture = 1'b1;
        state_d = HOLD;
      end else if (req) begin
        state_d = (state_q == SQUASH) ? SQUASH : FETCH;
      end
    end

    if (capture) begin
      instr_d = i_imem_rdata;
      inc_d   = pc_q + AW'(1);
      valid_d = 1'b1;
      pc_d    = pc_q + AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_ADDR;
      redir_q <= '0;
      inc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      inc_q   <= inc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = pc_q;
  assign o_if_valid  = valid_q;
  assign o_if_instr  = instr_q;
  assign o_if_inc_PC = inc_q;
  assign o_flush     = i_PCSrc;

`ifdef FETCH_PERF_EN
  logic discard;
  assign discard = (state_q != BOOT) & req & i_imem_ack &
                   (i_PCSrc | (state_q == SQUASH));

  fetch_perf_cnt u_perf_fetch (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (capture),
    .o_count (o_perf_fetch)
  );

  fetch_perf_cnt u_perf_squash (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (discard),
    .o_count (o_perf_squash)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_fetch_sequencer;

  import fetch_sequencer_pkg::*;

  localparam logic [29:0] RA = RESET_ADDR_DEFAULT;

  logic        clk = 1'b0;
  logic        rst, stall, pcsrc, ack;
  logic [29:0] target;
  logic [31:0] rdata;

  logic        req, valid, flush;
  logic [29:0] addr, inc;
  logic [31:0] instr;

  logic        w_req, w_valid, w_flush;
  logic [29:0] w_addr, w_inc;
  logic [31:0] w_instr;

`ifdef FETCH_PERF_EN
  logic [31:0] pf, ps, wpf, wps;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_PCSrc      (pcsrc),
    .i_target     (target),
    .o_imem_req   (req),
    .o_imem_addr  (addr),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .o_if_valid   (valid),
    .o_if_instr   (instr),
    .o_if_inc_PC  (inc),
    .o_flush      (flush)
`ifdef FETCH_PERF_EN
    , .o_perf_fetch(pf), .o_perf_squash(ps)
`endif
  );

  fetch_sequencer #(.RESET_ADDR(30'h3FFF_FFFF)) u_wrap (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (1'b0),
    .i_PCSrc      (1'b0),
    .i_target     (30'h0),
    .o_imem_req   (w_req),
    .o_imem_addr  (w_addr),
    .i_imem_ack   (w_req),
    .i_imem_rdata (32'h0),
    .o_if_valid   (w_valid),
    .o_if_instr   (w_instr),
    .o_if_inc_PC  (w_inc),
    .o_flush      (w_flush)
`ifdef FETCH_PERF_EN
    , .o_perf_fetch(wpf), .o_perf_squash(wps)
`endif
  );

  // Reference model: tracks the outstanding request and whether it is wrong-path.
  logic        m_boot, m_valid, m_out, m_wrong;
  logic [29:0] m_pc, m_inc, m_redir;
  logic [31:0] m_instr;
  int unsigned m_nf, m_nsq;

  function automatic logic exp_req(input logic st);
    if (m_boot) return 1'b0;
    if (m_out)  return 1'b1;
    return !m_valid || !st;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_valid = 1'b0; m_out = 1'b0; m_wrong = 1'b0;
    m_pc = RA; m_inc = '0; m_redir = '0; m_instr = '0;
    m_nf = 0; m_nsq = 0;
  endtask

  task automatic model_edge();
    logic r;
    r = exp_req(stall);
    if (m_boot) begin
      m_boot = 1'b0;
      if (pcsrc) m_pc = target;
      return;
    end
    m_valid = m_valid & stall;
    if (pcsrc) begin
      m_valid = 1'b0;
      if (r && ack) begin
        m_pc = target; m_out = 1'b0; m_wrong = 1'b0; m_nsq++;
      end else if (r) begin
        m_out = 1'b1; m_wrong = 1'b1; m_redir = target;
      end else begin
        m_pc = target;
      end
    end else if (r && ack) begin
      if (m_wrong) begin
        m_pc = m_redir; m_nsq++;
      end else begin
        m_instr = rdata; m_pc = m_pc + 30'd1; m_inc = m_pc; m_valid = 1'b1; m_nf++;
      end
      m_out = 1'b0; m_wrong = 1'b0;
    end else if (r) begin
      m_out = 1'b1;
    end
  endtask

  task automatic drive(input logic st, input logic pcs, input logic [29:0] tg,
                       input logic ak, input logic [31:0] rd);
    @(negedge clk);
    stall = st; pcsrc = pcs; target = tg; ack = ak; rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    #1;
    stall = 1'b0; pcsrc = 1'b0; target = '0; ack = 1'b0; rdata = '0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b0; pcsrc = 1'b0; target = '0; ack = 1'b0; rdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req); end
    n_tests++; if (addr !== RA) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", addr, RA); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_tests++; if (instr !== 32'h0 || inc !== 30'h0) begin
      n_fail++; $display("FAIL reset_if instr=%h inc=%h exp=0/0", instr, inc);
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd;
    logic [29:0] e;
    drive(1'b0, 1'b0, '0, 1'b0, 32'h0);
    n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL boot_req got=%b exp=0", req); end
    tick();
    for (int k = 0; k < 6; k++) begin
      rd = $urandom;
      e  = RA + 30'(k);
      drive(1'b0, 1'b0, '0, 1'b1, rd);
      n_tests++; if (req !== 1'b1 || addr !== e) begin
        n_fail++; $display("FAIL zw_req k=%0d req=%b addr=%h exp=1/%h", k, req, addr, e);
      end
      tick();
      #1;
      n_tests++; if (valid !== 1'b1 || inc !== e + 30'd1 || instr !== rd) begin
        n_fail++; $display("FAIL zw_cap k=%0d v=%b inc=%h instr=%h exp=1/%h/%h", k, valid, inc, instr, e + 30'd1, rd);
      end
    end
  endtask

  task automatic test_delayed_ack();
    logic [29:0] a0;
    int unsigned pulses = 0;
    for (int r = 0; r < 3; r++) begin
      a0 = m_pc;
      for (int w = 0; w < 4; w++) begin
        drive(1'b0, 1'b0, '0, (w == 3), $urandom);
        n_tests++; if (req !== 1'b1 || addr !== a0) begin
          n_fail++; $display("FAIL dly_addr r=%0d w=%0d req=%b addr=%h exp=1/%h", r, w, req, addr, a0);
        end
        tick();
        #1;
        if (valid === 1'b1) pulses++;
        n_tests++; if (valid !== (w == 3) || inc !== m_inc) begin
          n_fail++; $display("FAIL dly_valid r=%0d w=%0d v=%b inc=%h exp=%b/%h", r, w, valid, inc, (w == 3), m_inc);
        end
      end
    end
    n_tests++; if (pulses != 3) begin n_fail++; $display("FAIL dly_pulses got=%0d exp=3", pulses); end
  endtask

  task automatic test_stall();
    logic [31:0] h_instr;
    logic [29:0] h_inc;
    drive(1'b0, 1'b0, '0, 1'b1, $urandom);
    tick();
    h_instr = m_instr; h_inc = m_inc;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, '0, 1'b0, $urandom);
      n_tests++; if (req !== 1'b0 || valid !== 1'b1 || instr !== h_instr || inc !== h_inc) begin
        n_fail++; $display("FAIL stall_hold k=%0d req=%b v=%b instr=%h inc=%h exp=0/1/%h/%h", k, req, valid, instr, inc, h_instr, h_inc);
      end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, $urandom);
    n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL stall_release_req got=%b exp=1", req); end
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, $urandom);
    tick();
    #1;
    n_tests++; if (valid !== 1'b1 || inc !== h_inc + 30'd1) begin
      n_fail++; $display("FAIL stall_next v=%b inc=%h exp=1/%h", valid, inc, h_inc + 30'd1);
    end
  endtask

  task automatic test_redirect_squash();
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0); tick();
    for (int k = 0; k < 3; k++) begin drive(1'b0, 1'b0, '0, 1'b1, $urandom); tick(); end
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++; if (req !== 1'b1 || addr !== 30'h0010_0003) begin
      n_fail++; $display("FAIL sq_out req=%b addr=%h exp=1/00100003", req, addr);
    end
    tick();
    drive(1'b0, 1'b1, 30'h100, 1'b0, '0);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL sq_flush got=%b exp=1", flush); end
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    n_tests++; if (req !== 1'b1 || addr !== 30'h0010_0003 || flush !== 1'b0) begin
      n_fail++; $display("FAIL sq_wait req=%b addr=%h flush=%b exp=1/00100003/0", req, addr, flush);
    end
    tick();
    #1;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL sq_discard valid=%b exp=0", valid); end
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++; if (req !== 1'b1 || addr !== 30'h100) begin
      n_fail++; $display("FAIL sq_next req=%b addr=%h exp=1/00000100", req, addr);
    end
`ifdef FETCH_PERF_EN
    n_tests++; if (ps !== 32'd1 || pf !== 32'd3) begin
      n_fail++; $display("FAIL sq_perf squash=%0d fetch=%0d exp=1/3", ps, pf);
    end
`endif
    tick();
  endtask

  task automatic test_double_redirect();
    drive(1'b0, 1'b1, 30'h40, 1'b0, '0); tick();
    drive(1'b0, 1'b1, 30'h80, 1'b0, '0);
    n_tests++; if (req !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL dr_squash req=%b flush=%b exp=1/1", req, flush);
    end
    tick();
    drive(1'b0, 1'b0, '0, 1'b1, $urandom); tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++; if (req !== 1'b1 || addr !== 30'h80) begin
      n_fail++; $display("FAIL dr_next req=%b addr=%h exp=1/00000080", req, addr);
    end
    tick();
  endtask

  task automatic test_random();
    logic st, pcs, ak;
    for (int c = 0; c < 500; c++) begin
      st  = ($urandom_range(9) < 3);
      pcs = ($urandom_range(9) == 0);
      ak  = $urandom_range(1);
      drive(st, pcs, 30'($urandom), ak, $urandom);
      n_tests++;
      if (req !== exp_req(st) || addr !== m_pc || valid !== m_valid ||
          instr !== m_instr || inc !== m_inc || flush !== pcs) begin
        n_fail++;
        $display("FAIL rnd c=%0d req=%b/%b addr=%h/%h v=%b/%b instr=%h/%h inc=%h/%h flush=%b/%b",
                 c, req, exp_req(st), addr, m_pc, valid, m_valid, instr, m_instr, inc, m_inc, flush, pcs);
      end
      tick();
    end
`ifdef FETCH_PERF_EN
    #1;
    n_tests++; if (pf !== 32'(m_nf) || ps !== 32'(m_nsq)) begin
      n_fail++; $display("FAIL rnd_perf fetch=%0d/%0d squash=%0d/%0d", pf, m_nf, ps, m_nsq);
    end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    for (int k = 0; k < 10 && !m_out; k++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0); tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++; if (req !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req got=%b exp=1", req); end
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (req !== 1'b0 || addr !== RA || valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset req=%b addr=%h v=%b exp=0/%h/0", req, addr, valid, RA);
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk); #1;
    n_tests++; if (w_req !== 1'b0) begin n_fail++; $display("FAIL wrap_boot req=%b exp=0", w_req); end
    @(posedge clk); @(negedge clk); #1;
    n_tests++; if (w_req !== 1'b1 || w_addr !== 30'h3FFF_FFFF) begin
      n_fail++; $display("FAIL wrap_first req=%b addr=%h exp=1/3fffffff", w_req, w_addr);
    end
    @(posedge clk); @(negedge clk); #1;
    n_tests++; if (w_addr !== 30'h0 || w_valid !== 1'b1 || w_inc !== 30'h0 || w_instr !== 32'h0 || w_flush !== 1'b0) begin
      n_fail++; $display("FAIL wrap_second addr=%h v=%b inc=%h exp=0/1/0", w_addr, w_valid, w_inc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_stall();
    test_redirect_squash();
    test_double_redirect();
    test_random();
    test_reset_mid_fetch();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
